// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes and type-field layout.
// The type field sits in the top TYPE_W bits of every flit.
package noc_pkg;

   localparam int FLIT_SIZE = 32;
   localparam int TYPE_W    = 2;
   localparam int TYPE_OFS  = TYPE_W;

   localparam logic [TYPE_W-1:0] FLIT_HEAD   = 2'b10;
   localparam logic [TYPE_W-1:0] FLIT_BODY   = 2'b00;
   localparam logic [TYPE_W-1:0] FLIT_TAIL   = 2'b01;
   localparam logic [TYPE_W-1:0] FLIT_SINGLE = 2'b11;

   typedef logic [TYPE_W-1:0] flit_type_t;

   // HEAD and SINGLE both open a packet; BODY and TAIL continue one
   function automatic logic opens_pkt(flit_type_t t);
      return t[1];
   endfunction

endpackage

// File: rtl/vc_out_port_if.sv
// Crossbar-side request bundle and output link of one router output port.
// master drives requests and credits, slave is the output port itself.
interface vc_out_port_if
   import noc_pkg::*;
#(
   parameter int IN_CNT = 7,
   parameter int FLIT_W = FLIT_SIZE,
   parameter int VC_CNT = 4
) ();

   localparam int VCW = $clog2(VC_CNT);

   logic [IN_CNT-1:0]        in_valid;
   logic [IN_CNT*FLIT_W-1:0] in_flit;
   logic [IN_CNT*VCW-1:0]    in_vc;
   logic [IN_CNT-1:0]        in_grant;
   logic                     out_valid;
   logic [FLIT_W-1:0]        out_flit;
   logic [VCW-1:0]           out_vc;
   logic [VC_CNT-1:0]        credit_in;
   logic                     credit_err;

   modport master (
      output in_valid, in_flit, in_vc, credit_in,
      input  in_grant, out_valid, out_flit, out_vc, credit_err
   );

   modport slave (
      input  in_valid, in_flit, in_vc, credit_in,
      output in_grant, out_valid, out_flit, out_vc, credit_err
   );

endinterface

// File: rtl/vc_out_port_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from a rotating pointer.
// The pointer moves just past the winner on a grant and holds otherwise.
module rr_arbiter #(
   parameter int N = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_any
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW:0]   pos;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      pos     = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr_q} + (PW+1)'(k);
         if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
         if (!gnt_any && req[pos[PW-1:0]]) begin
            gnt[pos[PW-1:0]] = 1'b1;
            gnt_idx          = pos[PW-1:0];
            gnt_any          = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (gnt_any)
         ptr_d = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/vc_out_port.sv
// Router output port: round-robin, wormhole VC locking, per-VC credits.
// Define VC_OUT_PORT_OREG_EN for a second output register (latency 2).
module vc_out_port
   import noc_pkg::*;
#(
   parameter int IN_CNT     = 7,
   parameter int FLIT_W     = FLIT_SIZE,
   parameter int VC_CNT     = 4,
   parameter int CREDIT_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   vc_out_port_if.slave  bus
);

   localparam int VCW  = $clog2(VC_CNT);
   localparam int CW   = $clog2(CREDIT_MAX + 1);
   localparam int IW   = $clog2(IN_CNT);
   localparam int TLSB = FLIT_W - TYPE_OFS;

   logic [VC_CNT-1:0][CW-1:0] cnt_q, cnt_d;
   logic [VC_CNT-1:0]         lock_q, lock_d;
   logic [VC_CNT-1:0][IW-1:0] owner_q, owner_d;
   logic                      err_q, err_d;

   logic [IN_CNT-1:0] elig;
   logic [IN_CNT-1:0] gnt;
   logic [IW-1:0]     gnt_idx;
   logic              gnt_any;

   logic [FLIT_W-1:0] sel_flit;
   logic [VCW-1:0]    sel_vc;
   flit_type_t        sel_type;

   logic              ov_q, ov_d;
   logic [FLIT_W-1:0] of_q, of_d;
   logic [VCW-1:0]    oc_q, oc_d;

   // Wrong-type or foreign flits on a VC are simply not eligible: held off
   always_comb begin : elig_c
      logic [VCW-1:0] vc_i;
      flit_type_t     t_i;
      elig = '0;
      for (int i = 0; i < IN_CNT; i++) begin
         vc_i = bus.in_vc[i*VCW +: VCW];
         t_i  = bus.in_flit[i*FLIT_W+TLSB +: TYPE_W];
         if (bus.in_valid[i] && !reset && cnt_q[vc_i] != '0) begin
            if (!lock_q[vc_i])
               elig[i] = opens_pkt(t_i);
            else
               elig[i] = (owner_q[vc_i] == IW'(i)) && !opens_pkt(t_i);
         end
      end
   end

   rr_arbiter #(
      .N(IN_CNT)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (elig),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_comb begin
      sel_flit = '0;
      sel_vc   = '0;
      for (int i = 0; i < IN_CNT; i++) begin
         if (gnt[i]) begin
            sel_flit = bus.in_flit[i*FLIT_W +: FLIT_W];
            sel_vc   = bus.in_vc[i*VCW +: VCW];
         end
      end
      sel_type = sel_flit[TLSB +: TYPE_W];
   end

   always_comb begin : state_c
      logic dec;
      logic inc;
      cnt_d   = cnt_q;
      lock_d  = lock_q;
      owner_d = owner_q;
      err_d   = err_q;
      dec     = 1'b0;
      inc     = 1'b0;
      for (int v = 0; v < VC_CNT; v++) begin
         dec = gnt_any && (sel_vc == VCW'(v));
         inc = bus.credit_in[v];
         if (dec && !inc)
            cnt_d[v] = cnt_q[v] - 1'b1;
         else if (inc && !dec) begin
            // Extra credit at full depth: saturate and flag
            if (cnt_q[v] == CW'(CREDIT_MAX)) err_d = 1'b1;
            else                             cnt_d[v] = cnt_q[v] + 1'b1;
         end
      end
      if (gnt_any) begin
         if (sel_type == FLIT_HEAD) begin
            lock_d[sel_vc]  = 1'b1;
            owner_d[sel_vc] = gnt_idx;
         end else if (sel_type == FLIT_TAIL) begin
            lock_d[sel_vc] = 1'b0;
         end
      end
      ov_d = gnt_any;
      of_d = gnt_any ? sel_flit : of_q;
      oc_d = gnt_any ? sel_vc : oc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int v = 0; v < VC_CNT; v++)
            cnt_q[v] <= CW'(CREDIT_MAX);
         lock_q  <= '0;
         owner_q <= '0;
         err_q   <= 1'b0;
         ov_q    <= 1'b0;
         of_q    <= '0;
         oc_q    <= '0;
      end else begin
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
         owner_q <= owner_d;
         err_q   <= err_d;
         ov_q    <= ov_d;
         of_q    <= of_d;
         oc_q    <= oc_d;
      end
   end

`ifdef VC_OUT_PORT_OREG_EN
   logic              ov2_q, ov2_d;
   logic [FLIT_W-1:0] of2_q, of2_d;
   logic [VCW-1:0]    oc2_q, oc2_d;

   always_comb begin
      ov2_d = ov_q;
      of2_d = of_q;
      oc2_d = oc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ov2_q <= 1'b0;
         of2_q <= '0;
         oc2_q <= '0;
      end else begin
         ov2_q <= ov2_d;
         of2_q <= of2_d;
         oc2_q <= oc2_d;
      end
   end

   assign bus.out_valid = ov2_q;
   assign bus.out_flit  = of2_q;
   assign bus.out_vc    = oc2_q;
`else
   assign bus.out_valid = ov_q;
   assign bus.out_flit  = of_q;
   assign bus.out_vc    = oc_q;
`endif

   assign bus.in_grant   = gnt;
   assign bus.credit_err = err_q;

endmodule

// File: tb/tb_vc_out_port.sv
// Bench for vc_out_port: directed vector table, hand sequences, and
// randomized traffic against a packet-level reference model.
module tb_vc_out_port;
   import noc_pkg::*;

   localparam int N  = 7;
   localparam int W  = 32;
   localparam int V  = 4;
   localparam int CM = 4;
`ifdef VC_OUT_PORT_OREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vc_out_port_if #(.IN_CNT(N), .FLIT_W(W), .VC_CNT(V)) bus ();

   vc_out_port #(
      .IN_CNT(N), .FLIT_W(W), .VC_CNT(V), .CREDIT_MAX(CM)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic           rst;
      logic [N-1:0]   valid;
      logic [2*N-1:0] vcs;
      logic [2*N-1:0] typs;
      logic [V-1:0]   cr;
      logic [N-1:0]   exp_gnt;
   } vec_t;

   vec_t tbl[$];

   int m_cnt[V];
   bit m_lock[V];
   int m_owner[V];
   int m_rr;
   bit m_err;
   logic e1_v, e2_v;
   logic [W-1:0] e1_f, e2_f;
   logic [1:0] e1_c, e2_c;

   int n_vec = 0;
   int n_bad = 0;
   int seq = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [2*N-1:0] at(int i, logic [1:0] x);
      logic [2*N-1:0] r;
      r = '0;
      r[2*i +: 2] = x;
      return r;
   endfunction

   function automatic void add(logic rst, logic [N-1:0] valid,
                               logic [2*N-1:0] vcs, logic [2*N-1:0] typs,
                               logic [V-1:0] cr, logic [N-1:0] exp_gnt);
      vec_t x;
      x.rst = rst; x.valid = valid; x.vcs = vcs;
      x.typs = typs; x.cr = cr; x.exp_gnt = exp_gnt;
      tbl.push_back(x);
   endfunction

   task automatic m_reset();
      for (int v = 0; v < V; v++) begin
         m_cnt[v] = CM; m_lock[v] = 0; m_owner[v] = 0;
      end
      m_rr = 0; m_err = 0;
      e1_v = 0; e1_f = '0; e1_c = '0;
      e2_v = 0; e2_f = '0; e2_c = '0;
   endtask

   // A packet may start only on a free VC; only its owner may continue it
   function automatic bit m_elig(int i);
      logic [1:0] t;
      int c;
      if (!bus.in_valid[i]) return 0;
      c = int'(bus.in_vc[i*2 +: 2]);
      t = bus.in_flit[i*W+30 +: 2];
      if (m_cnt[c] == 0) return 0;
      if (!m_lock[c]) return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
      return (m_owner[c] == i) && ((t == FLIT_BODY) || (t == FLIT_TAIL));
   endfunction

   task automatic cycle(input vec_t x, output logic [N-1:0] g);
      int gi, gv;
      logic [W-1:0] gf;
      logic ev;
      logic [W-1:0] ef;
      logic [1:0] ec;
      @(negedge clk);
      reset = x.rst;
      bus.in_valid = x.valid;
      for (int i = 0; i < N; i++) begin
         bus.in_vc[i*2 +: 2] = x.vcs[i*2 +: 2];
         bus.in_flit[i*W +: W] = {x.typs[i*2 +: 2], 30'(seq)};
         seq++;
      end
      bus.credit_in = x.cr;
      #1;
      ev = (LAT == 2) ? e2_v : e1_v;
      ef = (LAT == 2) ? e2_f : e1_f;
      ec = (LAT == 2) ? e2_c : e1_c;
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, ev});
      if (ev) begin
         chk("out_flit", 64'(bus.out_flit), 64'(ef));
         chk("out_vc", 64'(bus.out_vc), 64'(ec));
      end
      chk("credit_err", {63'd0, bus.credit_err}, {63'd0, m_err});
      for (int v = 0; v < V; v++)
         chk("cnt", 64'(dut.cnt_q[v]), 64'(m_cnt[v]));
      g = '0;
      gi = -1;
      if (!x.rst)
         for (int k = 0; k < N; k++)
            if (gi < 0 && m_elig((m_rr + k) % N)) gi = (m_rr + k) % N;
      if (gi >= 0) g[gi] = 1'b1;
      chk("in_grant", 64'(bus.in_grant), 64'(g));
      if (x.rst) begin
         m_reset();
      end else begin
         gv = -1;
         gf = '0;
         if (gi >= 0) begin
            gv = int'(bus.in_vc[gi*2 +: 2]);
            gf = bus.in_flit[gi*W +: W];
         end
         for (int v = 0; v < V; v++) begin
            if (v == gv && !x.cr[v]) m_cnt[v]--;
            else if (v != gv && x.cr[v]) begin
               if (m_cnt[v] == CM) m_err = 1;
               else m_cnt[v]++;
            end
         end
         if (gi >= 0) begin
            if (gf[31:30] == FLIT_HEAD) begin
               m_lock[gv] = 1; m_owner[gv] = gi;
            end else if (gf[31:30] == FLIT_TAIL) begin
               m_lock[gv] = 0;
            end
            m_rr = (gi + 1) % N;
         end
         e2_v = e1_v; e2_f = e1_f; e2_c = e1_c;
         e1_v = (gi >= 0);
         if (gi >= 0) begin
            e1_f = gf; e1_c = 2'(gv);
         end
      end
   endtask

   logic [N-1:0] g;
   vec_t r;
   vec_t idle;

   initial begin
      localparam logic [1:0] S = FLIT_SINGLE;
      localparam logic [1:0] H = FLIT_HEAD;
      localparam logic [1:0] B = FLIT_BODY;
      localparam logic [1:0] T = FLIT_TAIL;
      logic [2*N-1:0] rr_vc, rr_ty, all_s;

      rr_vc = at(0, 2'd0) | at(3, 2'd1) | at(5, 2'd2);
      rr_ty = at(0, S) | at(3, S) | at(5, S);
      all_s = '0;
      for (int i = 0; i < N; i++) all_s = all_s | at(i, S);

      add(1, 7'h7f, '0, all_s, '0, 7'b0000000);
      add(0, 7'b0000100, at(2, 2'd1), at(2, S), '0, 7'b0000100);
      add(0, '0, '0, '0, '0, '0);
      add(1, '0, '0, '0, '0, '0);
      for (int k = 0; k < 4; k++) begin
         add(0, 7'b0101001, rr_vc, rr_ty, '0, 7'b0000001);
         add(0, 7'b0101001, rr_vc, rr_ty, '0, 7'b0001000);
         add(0, 7'b0101001, rr_vc, rr_ty, '0, 7'b0100000);
      end
      add(0, 7'b0101001, rr_vc, rr_ty, '0, 7'b0000000);
      add(1, '0, '0, '0, '0, '0);
      add(0, 7'b0010010, at(1, 2'd2) | at(4, 2'd2), at(1, H) | at(4, H),
          '0, 7'b0000010);
      add(0, 7'b0010010, at(1, 2'd2) | at(4, 2'd2), at(1, B) | at(4, H),
          '0, 7'b0000010);
      add(0, 7'b0010010, at(1, 2'd2) | at(4, 2'd2), at(1, T) | at(4, H),
          '0, 7'b0000010);
      add(0, 7'b0010000, at(4, 2'd2), at(4, H), '0, 7'b0010000);
      add(1, '0, '0, '0, '0, '0);
      for (int k = 0; k < 4; k++)
         add(0, 7'b0000001, '0, at(0, S), '0, 7'b0000001);
      add(0, 7'b0000001, '0, at(0, S), '0, 7'b0000000);
      add(0, 7'b0000001, '0, at(0, S), 4'b0001, 7'b0000000);
      add(0, 7'b0000001, '0, at(0, S), '0, 7'b0000001);
      add(0, 7'b0000001, '0, at(0, S), '0, 7'b0000000);
      add(1, '0, '0, '0, '0, '0);
      add(0, '0, '0, '0, 4'b1000, '0);
      add(0, '0, '0, '0, '0, '0);
      add(1, '0, '0, '0, '0, '0);
      add(0, 7'b0000001, at(0, 2'd3), at(0, S), 4'b1000, 7'b0000001);
      add(0, '0, '0, '0, '0, '0);
      add(1, '0, '0, '0, '0, '0);
      add(0, 7'b1000000, at(6, 2'd0), at(6, H), '0, 7'b1000000);
      add(1, 7'b1000010, '0, at(1, H) | at(6, H), '0, 7'b0000000);
      add(0, 7'b1000010, '0, at(1, H) | at(6, H), '0, 7'b0000010);
      add(0, '0, '0, '0, '0, '0);

      idle = '{rst: 0, valid: '0, vcs: '0, typs: '0, cr: '0, exp_gnt: '0};

      reset = 1'b1;
      bus.in_valid = '0;
      bus.in_flit = '0;
      bus.in_vc = '0;
      bus.credit_in = '0;
      repeat (2) @(posedge clk);
      m_reset();
      @(negedge clk);
      chk("rst_flit", 64'(bus.out_flit), 64'd0);
      chk("rst_vc", 64'(bus.out_vc), 64'd0);

      foreach (tbl[i]) begin
         cycle(tbl[i], g);
         chk("tbl_gnt", 64'(bus.in_grant), 64'(tbl[i].exp_gnt));
      end

      // Latency and credit decrement seen directly
      r = idle; r.rst = 1;
      cycle(r, g);
      r = idle; r.valid = 7'b0000100; r.vcs = at(2, 2'd1); r.typs = at(2, S);
      cycle(r, g);
      repeat (LAT) cycle(idle, g);
      chk("lat_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("lat_vc", 64'(bus.out_vc), 64'd1);
      chk("cnt1_dec", 64'(dut.cnt_q[1]), 64'd3);

      // Overflow flag stays set until reset
      r = idle; r.cr = 4'b1000;
      cycle(r, g);
      repeat (5) cycle(idle, g);
      chk("err_sticky", {63'd0, bus.credit_err}, 64'd1);
      chk("cnt3_sat", 64'(dut.cnt_q[3]), 64'd4);
      r = idle; r.rst = 1;
      cycle(r, g);
      cycle(idle, g);
      chk("err_clr", {63'd0, bus.credit_err}, 64'd0);

      for (int n = 0; n < 3000; n++) begin
         r.rst = ($urandom_range(0, 199) == 0);
         r.valid = N'($urandom);
         r.vcs = (2*N)'($urandom);
         r.typs = (2*N)'($urandom);
         for (int v = 0; v < V; v++) r.cr[v] = ($urandom_range(0, 3) == 0);
         r.exp_gnt = '0;
         cycle(r, g);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
